// File: rtl/result_writeback_arb.sv
// Per-lane result FIFOs merged onto one shared BRAM write port by a round-robin arbiter.
// Define RESULT_WB_STATS_EN to add the wr_count / drop_count statistics outputs.
module result_writeback_arb #(
    parameter  int N          = 4,
    parameter  int DW         = 2,
    parameter  int BRAM_DEPTH = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int RW         = 2*DW + $clog2(N),
    localparam int AW         = $clog2(BRAM_DEPTH),
    localparam int GAW        = $clog2(N*BRAM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*RW-1:0] lane_data,
    input  logic [N-1:0]    lane_wr_en,
    input  logic [N*AW-1:0] lane_wr_addr,
    output logic            bram_wr_en,
    output logic [GAW-1:0]  bram_wr_addr,
    output logic [RW-1:0]   bram_wr_data,
    input  logic            clr_ovf,
    output logic [N-1:0]    overflow,
`ifdef RESULT_WB_STATS_EN
    output logic [31:0]     wr_count,
    output logic [31:0]     drop_count,
`endif
    output logic            idle
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = AW + RW;

    logic [EW-1:0] r_mem  [N][FIFO_DEPTH];
    logic [PW-1:0] r_wptr [N];
    logic [PW-1:0] r_rptr [N];
    logic [LW-1:0] r_rr_ptr;

    logic [N-1:0]   w_empty;
    logic [N-1:0]   w_full;
    logic [N-1:0]   w_pop;
    logic [N-1:0]   w_push;
    logic [N-1:0]   w_drop;
    logic           w_grant_vld;
    logic [LW-1:0]  w_grant_lane;
    logic [EW-1:0]  w_head;
    logic [GAW-1:0] w_glob_addr;

    // Pointers carry one extra MSB so equal low bits can be told apart as full vs empty.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_empty[i] = (r_wptr[i] == r_rptr[i]);
            w_full[i]  = (r_wptr[i][PW-1] != r_rptr[i][PW-1]) &&
                         (r_wptr[i][PW-2:0] == r_rptr[i][PW-2:0]);
        end
    end

    // Walk from the highest offset down so the lane closest to r_rr_ptr wins.
    always_comb begin
        int sum;
        w_grant_vld  = 1'b0;
        w_grant_lane = '0;
        sum          = 0;
        for (int off = N-1; off >= 0; off--) begin
            sum = int'(r_rr_ptr) + off;
            if (sum >= N) begin
                sum = sum - N;
            end
            if (!w_empty[LW'(sum)]) begin
                w_grant_vld  = 1'b1;
                w_grant_lane = LW'(sum);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_pop[i]  = w_grant_vld && (w_grant_lane == LW'(i));
            w_push[i] = lane_wr_en[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = lane_wr_en[i] && w_full[i] && !w_pop[i];
        end
    end

    assign w_head      = r_mem[w_grant_lane][r_rptr[w_grant_lane][PW-2:0]];
    assign w_glob_addr = GAW'(w_grant_lane) * GAW'(BRAM_DEPTH) + GAW'(w_head[EW-1:RW]);

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i][PW-2:0]] <= {lane_wr_addr[i*AW +: AW], lane_data[i*RW +: RW]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            bram_wr_en   <= 1'b0;
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
        end else begin
            bram_wr_en <= w_grant_vld;
            if (w_grant_vld) begin
                r_rr_ptr     <= (w_grant_lane == LW'(N-1)) ? '0 : w_grant_lane + LW'(1);
                bram_wr_addr <= w_glob_addr;
                bram_wr_data <= w_head[RW-1:0];
            end
        end
    end

    // A drop in the same cycle as the clear leaves its flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= '0;
        end else begin
            overflow <= (clr_ovf ? '0 : overflow) | w_drop;
        end
    end

    assign idle = (&w_empty) && !bram_wr_en;

`ifdef RESULT_WB_STATS_EN
    logic [31:0] w_drop_n;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N; i++) begin
            w_drop_n = w_drop_n + 32'(w_drop[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count   <= '0;
            drop_count <= '0;
        end else begin
            if (w_grant_vld) begin
                wr_count <= wr_count + 32'd1;
            end
            drop_count <= drop_count + w_drop_n;
        end
    end
`endif

endmodule

// File: doc/result_writeback_arb.md
Name: result_writeback_arb

Overview:
- Downstream stage of the N-lane matrix-matrix engine.
- Accepts N independent per-lane result writes (data + lane-local address + write enable) and buffers each in a per-lane FIFO.
- Round-robin arbitrates the lanes onto one shared result BRAM write port, at most one write per cycle.
- The shared BRAM is partitioned into N regions of BRAM_DEPTH words, one region per lane.

Parameters:
- N, 4, number of lanes (matches the engine's N).
- DW, 2, element width; result width RW = 2*DW + $clog2(N).
- BRAM_DEPTH, 32, words per lane region; lane address width AW = $clog2(BRAM_DEPTH).
- FIFO_DEPTH, 4, entries per lane FIFO (power of 2, at least 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- lane_data  in  [RW-1:0] x [0:N-1]  per-lane result word.
- lane_wr_en  in  1 x [0:N-1]  per-lane write strobe, one word per high cycle.
- lane_wr_addr  in  [AW-1:0] x [0:N-1]  lane-local word address.
- bram_wr_en  out  1  shared BRAM write enable (registered).
- bram_wr_addr  out  $clog2(N*BRAM_DEPTH)  global address = lane*BRAM_DEPTH + lane_wr_addr (registered).
- bram_wr_data  out  RW  write data (registered).
- clr_ovf  in  1  synchronous clear of all overflow flags.
- overflow  out  N  sticky per-lane drop flags.
- idle  out  1  all FIFOs empty and no write pending on the output register.

Behaviour:
- Reset (async): bram_wr_en=0, bram_wr_addr=0, bram_wr_data=0, overflow=0, all FIFOs empty, rr_ptr=0, idle=1.
- Push: lane_wr_en[i]=1 with FIFO i not full, sampled at an edge → {lane_wr_addr[i], lane_data[i]} written into FIFO i. All lanes may push in the same cycle.
- Arbitration (combinational on FIFO non-empty flags):
  - Search starts at rr_ptr and wraps modulo N; the first non-empty lane k is granted.
  - Grant pops FIFO k and registers bram_wr_en=1, bram_wr_addr=k*BRAM_DEPTH+addr, bram_wr_data=data.
  - rr_ptr then becomes (k+1) mod N.
  - No grant → bram_wr_en=0 next cycle; addr/data hold their last values; rr_ptr holds.
- Latency: push at edge t → FIFO non-empty in cycle t → bram_wr_en high in cycle t+1 (no contention). No same-cycle bypass.
- Throughput: 1 write/cycle total. With all N lanes continuously backlogged, each lane gets exactly 1 of every N grants.
- Full FIFO and push:
  - If the same lane is popped that cycle, the push is accepted (count unchanged).
  - Otherwise the word is dropped, overflow[i] is set sticky, and FIFO contents are unchanged.
- Empty FIFO with push: the word is not eligible for arbitration until the next cycle.
- clr_ovf=1 clears overflow; a simultaneous drop on lane i in that same cycle wins and overflow[i]=1.
- FIFO pointers: $clog2(FIFO_DEPTH)+1 bits; wrap-around is handled by the MSB full/empty distinction.
- idle = all FIFOs empty AND bram_wr_en==0.
- Reset mid-operation: buffered and pending writes are discarded; bram_wr_en falls immediately (asynchronous).

Optional Feature:
- Macro: RESULT_WB_STATS_EN.
- Defined:
  - Adds output wr_count [31:0], counting granted writes (bram_wr_en cycles).
  - Adds output drop_count [31:0], counting dropped lane words; multiple drops in one cycle add their total.
  - Both reset to 0, wrap modulo 2^32, and are not affected by clr_ovf.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan (N=4, DW=2, BRAM_DEPTH=32, FIFO_DEPTH=4, RW=6):
- Single write: lane2 pushes data=6'h2A, addr=5 at edge t → cycle t+1: bram_wr_en=1, bram_wr_addr=69, data=6'h2A; cycle t+2: bram_wr_en=0, idle=1.
- Round-robin: all 4 lanes push 1 word in the same cycle with rr_ptr=0 → outputs ordered lanes 0,1,2,3 on 4 consecutive cycles, addresses 0+a0, 32+a1, 64+a2, 96+a3.
- Fairness: lanes 1 and 3 backlogged with 3 words each, rr_ptr=2 → grant order 3,1,3,1,3,1.
- Overflow: lane0 pushes 6 words in 6 consecutive cycles while lanes 1–3 are held backlogged → overflow[0]=1 after the first drop. The words that do get written to addresses 0..31 all match the pushed sequence, in order. clr_ovf → overflow=0.
- Full with simultaneous pop: lane0 FIFO full, lane0 granted and pushed in the same cycle → no drop, overflow[0] stays 0.
- Async reset: rst asserted mid-stream with 3 words buffered → bram_wr_en=0 immediately, idle=1. With RESULT_WB_STATS_EN defined, wr_count=0 and drop_count=0.
